// File: rtl/tcam_ctrl_pkg.sv
// Shared types and sizes for the TCAM controller and its helpers.
package tcam_ctrl_pkg;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 16;

    localparam logic OP_INSERT = 1'b0;
    localparam logic OP_DELETE = 1'b1;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        WRITE,
        SEARCH
    } state_t;

    typedef enum logic {
        PRIO_UPD,
        PRIO_LK
    } prio_t;

    function automatic logic [AW:0] count_ones(input logic [DEPTH-1:0] v);
        logic [AW:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + {{AW{1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tcam_free_finder.sv
// Finds the lowest-index entry whose valid bit is clear; flags a full table.
module tcam_free_finder
    import tcam_ctrl_pkg::*;
(
    input  logic [DEPTH-1:0] valid,
    output logic [AW-1:0]    free_addr,
    output logic             full
);

    // Scan from the top so the lowest free index is the last one assigned.
    always_comb begin
        free_addr = '0;
        full      = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_addr = AW'(i);
                full      = 1'b0;
            end
        end
    end

endmodule

// File: rtl/tcam_ctrl.sv
// Sequencer and arbiter for a 16x16 ternary CAM: initialises every entry,
// serves update and lookup clients, and masks stale entries via a valid bitmap.
module tcam_ctrl
    import tcam_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          reset,

    input  logic          upd_valid,
    output logic          upd_ready,
    input  logic          upd_op,
    input  logic          upd_auto,
    input  logic [AW-1:0] upd_addr,
    input  logic [DW-1:0] upd_data,
    input  logic [DW-1:0] upd_mask,
    output logic          upd_rsp_valid,
    output logic [AW-1:0] upd_rsp_addr,
    output logic          upd_rsp_err,

    input  logic          lk_valid,
    output logic          lk_ready,
    input  logic [DW-1:0] lk_key,
    output logic          res_valid,
    output logic          res_hit,
    output logic [AW-1:0] res_addr,

    output logic [AW:0]   occ_count,
    output logic          busy,

    output logic [DW-1:0] tcam_data,
    output logic [DW-1:0] tcam_dontcare,
    output logic          tcam_write_readN,
    output logic [AW-1:0] tcam_write_address,
    output logic          tcam_resetN,
    input  logic [AW-1:0] tcam_found_address,
    input  logic          tcam_found_any
);

    state_t           state;
    prio_t            prio;
    logic [AW-1:0]    init_cnt;
    logic [DEPTH-1:0] valid;

    logic             op_q;
    logic             err_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    data_q;
    logic [DW-1:0]    mask_q;
    logic [DW-1:0]    key_q;

    logic [AW-1:0]    free_addr;
    logic             full;
    logic             upd_fire;
    logic             lk_fire;
    logic             both_req;
    logic             auto_ins;
    logic             search_hit;

    tcam_free_finder u_free_finder (
        .valid     (valid),
        .free_addr (free_addr),
        .full      (full)
    );

    assign upd_ready  = (state == IDLE) && (!lk_valid  || prio == PRIO_UPD);
    assign lk_ready   = (state == IDLE) && (!upd_valid || prio == PRIO_LK);
    assign upd_fire   = upd_valid && upd_ready;
    assign lk_fire    = lk_valid && lk_ready;
    assign both_req   = upd_valid && lk_valid;
    assign auto_ins   = (upd_op == OP_INSERT) && upd_auto;
    assign search_hit = tcam_found_any && valid[tcam_found_address];

    assign busy        = (state != IDLE);
    assign occ_count   = count_ones(valid);
    assign tcam_resetN = ~reset;

    // The TCAM drive is decoded from registered state; the write strobe is held
    // off while reset is asserted so the array only sees writes out of reset.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        tcam_write_readN   = 1'b0;
        tcam_write_address = addr_q;
        tcam_data          = key_q;
        tcam_dontcare      = '0;
        case (state)
            INIT: begin
                tcam_write_readN   = !reset;
                tcam_write_address = init_cnt;
                tcam_data          = '0;
            end
            WRITE: begin
                tcam_write_readN = !err_q;
                tcam_data        = data_q;
                tcam_dontcare    = mask_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state         <= INIT;
            prio          <= PRIO_UPD;
            init_cnt      <= '0;
            valid         <= '0;
            op_q          <= OP_INSERT;
            err_q         <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            mask_q        <= '0;
            key_q         <= '0;
            upd_rsp_valid <= 1'b0;
            upd_rsp_addr  <= '0;
            upd_rsp_err   <= 1'b0;
            res_valid     <= 1'b0;
            res_hit       <= 1'b0;
            res_addr      <= '0;
        end else begin
            upd_rsp_valid <= 1'b0;
            res_valid     <= 1'b0;
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == AW'(DEPTH - 1)) state <= IDLE;
                end
                IDLE: begin
                    if (upd_fire) begin
                        state  <= WRITE;
                        op_q   <= upd_op;
                        err_q  <= auto_ins && full;
                        addr_q <= auto_ins ? free_addr : upd_addr;
                        data_q <= (upd_op == OP_DELETE) ? '0 : upd_data;
                        mask_q <= (upd_op == OP_DELETE) ? '0 : upd_mask;
                        if (both_req) prio <= PRIO_LK;
                    end else if (lk_fire) begin
                        state <= SEARCH;
                        key_q <= lk_key;
                        if (both_req) prio <= PRIO_UPD;
                    end
                end
                WRITE: begin
                    state         <= IDLE;
                    upd_rsp_valid <= 1'b1;
                    upd_rsp_err   <= err_q;
                    upd_rsp_addr  <= addr_q;
                    if (!err_q) valid[addr_q] <= (op_q == OP_INSERT);
                end
                SEARCH: begin
                    state     <= IDLE;
                    res_valid <= 1'b1;
                    res_hit   <= search_hit;
                    res_addr  <= search_hit ? tcam_found_address : '0;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_tcam_ctrl.sv
// Self-checking bench for tcam_ctrl: behavioural TCAM array plus a table-level
// reference model of entries, validity and priority matching.
module tb_tcam_ctrl;
    import tcam_ctrl_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          upd_valid = 1'b0;
    logic          upd_ready;
    logic          upd_op = 1'b0;
    logic          upd_auto = 1'b0;
    logic [AW-1:0] upd_addr = '0;
    logic [DW-1:0] upd_data = '0;
    logic [DW-1:0] upd_mask = '0;
    logic          upd_rsp_valid;
    logic [AW-1:0] upd_rsp_addr;
    logic          upd_rsp_err;
    logic          lk_valid = 1'b0;
    logic          lk_ready;
    logic [DW-1:0] lk_key = '0;
    logic          res_valid;
    logic          res_hit;
    logic [AW-1:0] res_addr;
    logic [AW:0]   occ_count;
    logic          busy;
    logic [DW-1:0] tcam_data;
    logic [DW-1:0] tcam_dontcare;
    logic          tcam_write_readN;
    logic [AW-1:0] tcam_write_address;
    logic          tcam_resetN;
    logic [AW-1:0] tcam_found_address;
    logic          tcam_found_any;

    always #5 clk = ~clk;

    tcam_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .upd_valid          (upd_valid),
        .upd_ready          (upd_ready),
        .upd_op             (upd_op),
        .upd_auto           (upd_auto),
        .upd_addr           (upd_addr),
        .upd_data           (upd_data),
        .upd_mask           (upd_mask),
        .upd_rsp_valid      (upd_rsp_valid),
        .upd_rsp_addr       (upd_rsp_addr),
        .upd_rsp_err        (upd_rsp_err),
        .lk_valid           (lk_valid),
        .lk_ready           (lk_ready),
        .lk_key             (lk_key),
        .res_valid          (res_valid),
        .res_hit            (res_hit),
        .res_addr           (res_addr),
        .occ_count          (occ_count),
        .busy               (busy),
        .tcam_data          (tcam_data),
        .tcam_dontcare      (tcam_dontcare),
        .tcam_write_readN   (tcam_write_readN),
        .tcam_write_address (tcam_write_address),
        .tcam_resetN        (tcam_resetN),
        .tcam_found_address (tcam_found_address),
        .tcam_found_any     (tcam_found_any)
    );

    // Behavioural TCAM: clocked writes, combinational lowest-index match.
    logic [DW-1:0] cam_data [DEPTH];
    logic [DW-1:0] cam_mask [DEPTH];

    always @(posedge clk) begin
        if (tcam_resetN && tcam_write_readN) begin
            cam_data[tcam_write_address] <= tcam_data;
            cam_mask[tcam_write_address] <= tcam_dontcare;
        end
    end

    always_comb begin
        tcam_found_any     = 1'b0;
        tcam_found_address = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (((tcam_data ^ cam_data[i]) & ~cam_mask[i]) == '0) begin
                tcam_found_any     = 1'b1;
                tcam_found_address = AW'(i);
            end
        end
    end

    // Reference model of the table contents as the clients see them.
    bit            ref_valid [DEPTH];
    logic [DW-1:0] ref_data  [DEPTH];
    logic [DW-1:0] ref_mask  [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int ref_occ();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += ref_valid[i] ? 1 : 0;
        return n;
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < DEPTH; i++) begin
            ref_valid[i] = 1'b0;
            ref_data[i]  = '0;
            ref_mask[i]  = '0;
        end
    endtask

    // Holds reset, checks the reset state, then walks the 16 INIT writes.
    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        upd_valid = 1'b0;
        lk_valid  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_upd_ready", upd_ready, 0);
        check("rst_lk_ready", lk_ready, 0);
        check("rst_rsp_valid", upd_rsp_valid, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_write_readN", tcam_write_readN, 0);
        check("rst_occ", occ_count, 0);
        check("rst_resetN", tcam_resetN, 0);
        ref_clear();
        reset = 1'b0;
        #1;
        for (int k = 0; k < DEPTH; k++) begin
            check("init_busy", busy, 1);
            check("init_write", tcam_write_readN, 1);
            check("init_addr", tcam_write_address, k);
            check("init_data", tcam_data, 0);
            check("init_mask", tcam_dontcare, 0);
            check("init_resetN", tcam_resetN, 1);
            @(negedge clk);
        end
        check("init_done_busy", busy, 0);
        check("init_done_lk_ready", lk_ready, 1);
        check("init_done_upd_ready", upd_ready, 1);
        check("init_done_occ", occ_count, 0);
    endtask

    task automatic do_update(input logic op, input logic auto_m, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input logic [DW-1:0] mask);
        int            n;
        logic          exp_err;
        logic [AW-1:0] exp_addr;
        upd_valid = 1'b1;
        upd_op    = op;
        upd_auto  = auto_m;
        upd_addr  = addr;
        upd_data  = data;
        upd_mask  = mask;
        #1;
        n = 0;
        while (!upd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("upd_handshake", upd_ready, 1);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        upd_op    = 1'($urandom);
        upd_auto  = 1'($urandom);
        upd_addr  = AW'($urandom);
        upd_data  = DW'($urandom);
        upd_mask  = DW'($urandom);

        exp_err  = 1'b0;
        exp_addr = addr;
        if (op == OP_INSERT && auto_m) begin
            exp_err  = 1'b1;
            exp_addr = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (exp_err && !ref_valid[i]) begin
                    exp_err  = 1'b0;
                    exp_addr = AW'(i);
                end
            end
        end
        if (!exp_err) begin
            ref_valid[exp_addr] = (op == OP_INSERT);
            ref_data[exp_addr]  = (op == OP_INSERT) ? data : '0;
            ref_mask[exp_addr]  = (op == OP_INSERT) ? mask : '0;
        end

        @(negedge clk);
        check("upd_c1_busy", busy, 1);
        check("upd_c1_rsp_valid", upd_rsp_valid, 0);
        check("upd_c1_write", tcam_write_readN, !exp_err);
        if (!exp_err) begin
            check("upd_c1_waddr", tcam_write_address, exp_addr);
            check("upd_c1_wdata", tcam_data, ref_data[exp_addr]);
            check("upd_c1_wmask", tcam_dontcare, ref_mask[exp_addr]);
        end
        @(negedge clk);
        check("upd_c2_rsp_valid", upd_rsp_valid, 1);
        check("upd_c2_rsp_addr", upd_rsp_addr, exp_addr);
        check("upd_c2_rsp_err", upd_rsp_err, exp_err);
        check("upd_c2_occ", occ_count, ref_occ());
        check("upd_c2_busy", busy, 0);
    endtask

    task automatic do_lookup(input logic [DW-1:0] key);
        int            n;
        bit            found;
        logic          exp_hit;
        logic [AW-1:0] exp_addr;
        lk_valid = 1'b1;
        lk_key   = key;
        #1;
        n = 0;
        while (!lk_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("lk_handshake", lk_ready, 1);
        @(posedge clk);
        #1;
        lk_valid = 1'b0;
        lk_key   = DW'($urandom);

        // The array reports only its first match; that entry decides the result.
        found    = 1'b0;
        exp_hit  = 1'b0;
        exp_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && ((key ^ ref_data[i]) & ~ref_mask[i]) == '0) begin
                found    = 1'b1;
                exp_hit  = ref_valid[i];
                exp_addr = ref_valid[i] ? AW'(i) : '0;
            end
        end

        @(negedge clk);
        check("lk_c1_res_valid", res_valid, 0);
        check("lk_c1_write", tcam_write_readN, 0);
        check("lk_c1_key", tcam_data, key);
        check("lk_c1_rsp_valid", upd_rsp_valid, 0);
        @(negedge clk);
        check("lk_c2_res_valid", res_valid, 1);
        check("lk_c2_hit", res_hit, exp_hit);
        check("lk_c2_addr", res_addr, exp_addr);
    endtask

    // Both clients request continuously; grants must alternate from upd.
    task automatic arb_test();
        int n;
        upd_valid = 1'b1;
        upd_op    = OP_DELETE;
        upd_auto  = 1'b0;
        upd_addr  = AW'(5);
        lk_valid  = 1'b1;
        lk_key    = DW'($urandom);
        #1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!upd_ready && !lk_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("arb_upd_grant", upd_ready, (g % 2) == 0);
            check("arb_lk_grant", lk_ready, (g % 2) == 1);
            @(posedge clk);
            #1;
        end
        upd_valid = 1'b0;
        lk_valid  = 1'b0;
        repeat (3) @(negedge clk);
        check("arb_idle_busy", busy, 0);
    endtask

    task automatic reset_during_search();
        int n;
        lk_valid = 1'b1;
        lk_key   = DW'($urandom);
        #1;
        n = 0;
        while (!lk_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_handshake", lk_ready, 1);
        @(posedge clk);
        #1;
        lk_valid = 1'b0;
        @(negedge clk);
        check("rstmid_busy_search", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_no_res", res_valid, 0);
        check("rstmid_busy", busy, 1);
        apply_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apply_reset();

        do_update(OP_INSERT, 1'b1, '0, 16'h6E6E, 16'h8787);
        check("dir_rsp_addr0", upd_rsp_addr, 0);
        do_update(OP_INSERT, 1'b1, '0, 16'h8000, 16'h3FFF);
        check("dir_rsp_addr1", upd_rsp_addr, 1);
        check("dir_occ2", occ_count, 2);

        do_lookup(16'h6E6E);
        check("dir_hit0", res_hit, 1);
        do_lookup(16'h9235);
        check("dir_hit1_addr", res_addr, 1);
        do_lookup(16'h0001);
        check("dir_miss", res_hit, 0);

        do_update(OP_DELETE, 1'b0, AW'(0), 16'hFFFF, 16'hFFFF);
        do_lookup(16'h6E6E);
        check("dir_del_miss", res_hit, 0);
        check("dir_occ1", occ_count, 1);
        do_update(OP_DELETE, 1'b0, AW'(0), 16'h1234, 16'h0000);
        check("dir_redelete_err", upd_rsp_err, 0);

        apply_reset();
        arb_test();

        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            do_update(OP_INSERT, 1'b1, AW'($urandom), DW'($urandom), DW'($urandom));
            check("fill_addr", upd_rsp_addr, i);
        end
        check("fill_occ16", occ_count, 16);
        do_update(OP_INSERT, 1'b1, '0, DW'($urandom), DW'($urandom));
        check("fill_full_err", upd_rsp_err, 1);

        for (int t = 0; t < 120; t++) begin
            int            r;
            int            idx;
            logic [DW-1:0] key;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            r = $urandom_range(0, 9);
            if (r < 4) begin
                idx = $urandom_range(0, DEPTH - 1);
                if ($urandom_range(0, 3) != 0) key = ref_data[idx] ^ (DW'($urandom) & ref_mask[idx]);
                else key = DW'($urandom);
                do_lookup(key);
            end else if (r < 6) begin
                do_update(OP_INSERT, 1'b1, AW'($urandom), DW'($urandom), DW'($urandom));
            end else if (r < 8) begin
                do_update(OP_INSERT, 1'b0, AW'($urandom_range(0, DEPTH - 1)), DW'($urandom), DW'($urandom));
            end else begin
                do_update(OP_DELETE, 1'b0, AW'($urandom_range(0, DEPTH - 1)), DW'($urandom), DW'($urandom));
            end
        end

        reset_during_search();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
